stateless_alu_pipe: RTL

//   Pipelined, parametrised successor to the single-cycle stateless packet ALU atom.

---
 rtl/stateless_alu_pipe_if.sv | 28 ++
 rtl/stateless_alu_pipe.sv | 118 +++++++++++
 2 files changed

// File: rtl/stateless_alu_pipe_if.sv
// stateless_alu_pipe_if: config, input-stream and output-stream signals of the stateless ALU pipe
interface stateless_alu_pipe_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 32
);
    logic                 cfg_we;
    logic [3:0]           cfg_opcode;
    logic [WIDTH-1:0]     cfg_cons;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     pkt_1;
    logic [WIDTH-1:0]     pkt_2;
    logic [WIDTH-1:0]     pkt_3;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     o_write;
    logic [CNT_WIDTH-1:0] pkt_count;

    modport master (
        output cfg_we, cfg_opcode, cfg_cons, in_valid, pkt_1, pkt_2, pkt_3, out_ready,
        input  in_ready, out_valid, o_write, pkt_count
    );

    modport slave (
        input  cfg_we, cfg_opcode, cfg_cons, in_valid, pkt_1, pkt_2, pkt_3, out_ready,
        output in_ready, out_valid, o_write, pkt_count
    );
endinterface

// File: rtl/stateless_alu_pipe.sv
// stateless_alu_pipe: two-stage valid/ready packet ALU with a registered opcode/constant config
module stateless_alu_pipe #(
    parameter int         WIDTH      = 32,
    parameter int         CNT_WIDTH  = 32,
    parameter logic [3:0] RST_OPCODE = 4'd0
) (
    input logic                 clk,
    input logic                 rst_n,
    stateless_alu_pipe_if.slave bus
);
    localparam logic [WIDTH:0] LP_WIDTH = (WIDTH+1)'(WIDTH);

    logic [3:0]           r_opcode;
    logic [WIDTH-1:0]     r_cons;
    logic                 r_s1_valid;
    logic [3:0]           r_s1_op;
    logic [WIDTH-1:0]     r_s1_k;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_c;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_o_write;
    logic [CNT_WIDTH-1:0] r_pkt_count;

    logic                 w_s2_ready;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_handoff;
    logic                 w_big_k;
    logic [WIDTH-1:0]     w_result;

    assign w_s2_ready = !r_out_valid || bus.out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_handoff  = r_out_valid && bus.out_ready;
    assign w_big_k    = {1'b0, r_s1_k} >= LP_WIDTH;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.o_write   = r_o_write;
    assign bus.pkt_count = r_pkt_count;

    // Config register; a packet accepted alongside a write still sees the old value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_opcode <= RST_OPCODE;
            r_cons   <= '0;
        end else if (bus.cfg_we) begin
            r_opcode <= bus.cfg_opcode;
            r_cons   <= bus.cfg_cons;
        end
    end

    // Stage 1: capture packet fields together with the config in force at acceptance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_k     <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
        end else begin
            if (w_in_ready)
                r_s1_valid <= bus.in_valid;
            if (w_accept) begin
                r_s1_op <= r_opcode;
                r_s1_k  <= r_cons;
                r_a     <= bus.pkt_1;
                r_b     <= bus.pkt_2;
                r_c     <= bus.pkt_3;
            end
        end
    end

    // Opcode-selected function of the stage-1 operands
    always_comb begin
        w_result = '0;
        case (r_s1_op)
            4'd0:    w_result = r_a + r_b;
            4'd1:    w_result = r_a - r_b;
            4'd2:    w_result = r_a & r_b;
            4'd3:    w_result = r_a ^ r_b;
            4'd4:    w_result = r_a | r_b;
            4'd5:    w_result = r_a + r_s1_k;
            4'd6:    w_result = r_a - r_s1_k;
            4'd7:    w_result = WIDTH'(r_a == r_b);
            4'd8:    w_result = WIDTH'(r_a != r_b);
            4'd9:    w_result = WIDTH'(r_a >= r_b);
            4'd10:   w_result = WIDTH'(r_a < r_b);
            4'd11:   w_result = w_big_k ? '0 : r_a << r_s1_k;
            4'd12:   w_result = w_big_k ? '0 : r_a >> r_s1_k;
            4'd13:   w_result = (r_a != '0) ? r_b : r_c;
            4'd14:   w_result = r_a;
            default: w_result = '0;
        endcase
    end

    // Stage 2: result register, frozen while the output is stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_o_write   <= '0;
        end else if (w_s2_ready) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid)
                r_o_write <= w_result;
        end
    end

    // Completed-packet counter, wrapping naturally at its width
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_pkt_count <= '0;
        else if (w_handoff)
            r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
    end
endmodule
